tile_sequence_checker: RTL and testbench
========================================

# tile_sequence_checker

- Consumer end of the random-tile stream: samples the 3-bit random tile number, one new tile per round, and stores the growing sequence in a buffer.
- Each round it plays the whole sequence to the display side, then checks the player's button presses against it.
- Sits between the random generator and the display/button logic of the tile-flip game; it owns round progression, win/fail and score.

## Interface
- `MAX_LEN`, default 16: maximum sequence length; reaching it and matching ends the game in a win.
- `SHOW_CYCLES`, default 50_000_000: cycles each tile is shown.
- `GAP_CYCLES`, default 12_500_000: blank cycles after each shown tile.
- `TIMEOUT_CYCLES`, default 250_000_000: input timeout; used only with `TILE_TIMEOUT_EN`.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; begins a new game when sampled high in IDLE, WIN or FAIL.
- `random_num`  in  3  tile number from the random generator; sampled only in CAPTURE.
- `btn_valid`  in  1  single-cycle pulse, one per player press.
- `btn_tile`  in  3  tile pressed; qualified by `btn_valid`.
- `show_valid`  out  1  high while a tile is being displayed.
- `show_tile`  out  3  tile being displayed; 0 when `show_valid` is low.
- `busy`  out  1  high in every state except IDLE, WIN and FAIL.
- `round_len`  out  $clog2(MAX_LEN+1)  current sequence length.
- `score`  out  $clog2(MAX_LEN+1)  number of fully completed rounds.
- `win`  out  1  level; high in WIN.
- `fail`  out  1  level; high in FAIL.

## Operation
- States: IDLE, CAPTURE, SHOW, GAP, INPUT, CHECK_END, WIN, FAIL.
- **IDLE/WIN/FAIL**
  - On `start`: `round_len`<=1, `score`<=0, `win`/`fail`<=0; go to CAPTURE.
  - `start` in any other state is ignored.
- **CAPTURE** (1 cycle): `buf[round_len-1]`<=`random_num`; reset the play index to 0 and the dwell counter to 0; go to SHOW.
- **SHOW**
  - `show_valid`=1, `show_tile`=`buf[idx]`.
  - After `SHOW_CYCLES` cycles, go to GAP.
- **GAP**
  - `show_valid`=0, `show_tile`=0.
  - After `GAP_CYCLES` cycles: if `idx`==`round_len-1`, clear `idx` and go to INPUT; else `idx`++ and go to SHOW.
- **INPUT**
  - On `btn_valid`, compare `btn_tile` with `buf[idx]`.
  - Mismatch: go to FAIL.
  - Match with `idx`<`round_len-1`: `idx`++.
  - Match with `idx`==`round_len-1`: go to CHECK_END.
  - `btn_valid` outside INPUT is ignored.
- **CHECK_END** (1 cycle): `score`++; if `round_len`==`MAX_LEN`, go to WIN; else `round_len`++ and go to CAPTURE.
- The sequence is cumulative: earlier buffer entries are never rewritten within a game.
- All counters are unsigned; the dwell counter width is `$clog2` of the largest of the three cycle parameters.

## Timing
- Reset values: state IDLE; `show_valid`, `show_tile`, `busy`, `round_len`, `score`, `win`, `fail` all 0; buffer contents don't-care.
- Reset mid-game aborts immediately to the reset values; no partial round survives.
- All outputs are registered.
- `start` sampled at edge k: CAPTURE after k, `show_valid` rises after edge k+1.
- Each tile: `show_valid` high for exactly `SHOW_CYCLES` cycles, then low for exactly `GAP_CYCLES` cycles.
- INPUT is entered on the cycle after the last GAP ends; a `btn_valid` on that same entry cycle is accepted.
- Last correct press sampled at edge m: CHECK_END after m, CAPTURE after m+1, next `show_valid` after m+2.
- `start` and `btn_valid` together in INPUT: `btn_valid` wins (`start` is ignored).
- `random_num`==0 is a legal tile and is stored as-is.

## Configuration
- `TILE_TIMEOUT_EN` defined:
  - An idle counter runs in INPUT and clears on every `btn_valid`.
  - Reaching `TIMEOUT_CYCLES` forces FAIL.
  - `score` is unchanged by the timeout.
- `TILE_TIMEOUT_EN` undefined: no counter is built; INPUT waits indefinitely.

## Structure
- Package `tile_pkg`:
  - `TILE_W`=3.
  - State enum `tile_state_t`.
  - `tile_t` typedef (logic [TILE_W-1:0]).
- Sub-module `tile_seq_buffer`:
  - `MAX_LEN` x `TILE_W` register file.
  - One synchronous write port, one combinational read port.
  - No reset on contents.
- Top holds the FSM, dwell/index counters, score and optional timeout counter.

## Test plan
(`MAX_LEN`=4, `SHOW_CYCLES`=4, `GAP_CYCLES`=2, `TIMEOUT_CYCLES`=20 throughout.)
- **Reset:** assert `reset_n`=0 mid-SHOW -> all outputs 0 same cycle; state IDLE after release.
- **Round 1:** `random_num`=5, pulse `start` -> `show_valid` high 4 cycles with `show_tile`=5, low 2 cycles; press 5 -> `score`=1, `round_len`=2.
- **Wrong press:** round 2 sequence 5,3; press 5 then 6 -> `fail`=1, `score`=1, `busy`=0; `start` -> `round_len`=1, `fail`=0.
- **Full game:** feed 1,2,7,0 and answer every round correctly -> `win`=1, `score`=4, `round_len`=4; further `btn_valid` has no effect.
- **Ignored inputs:** `btn_valid` during SHOW and `start` during INPUT -> no state, score or buffer change.
- **Timeout (with `TILE_TIMEOUT_EN`):** no press for 20 cycles in INPUT -> `fail`=1; same stimulus without the macro -> still in INPUT after 100 cycles.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared types for the tile-flip game sequence checker.
package tile_pkg;

  localparam int unsigned TILE_W = 3;

  typedef logic [TILE_W-1:0] tile_t;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StShow,
    StGap,
    StInput,
    StCheckEnd,
    StWin,
    StFail
  } tile_state_t;

  // Largest of three cycle counts; sizes the shared dwell counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tile_seq_buffer.sv
// Tile sequence storage: one synchronous write port, one combinational read port.
// Contents are not reset; the checker only reads entries it has already written.
module tile_seq_buffer
  import tile_pkg::*;
#(
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  tile_t            wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output tile_t            rdata_o
);

  tile_t mem_q [Depth];

  // Write the captured tile into its slot.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tile_sequence_checker.sv
// Tile-flip game sequence checker: captures one random tile per round, plays the
// whole sequence to the display, then checks the player's presses against it.
// Optional macro TILE_TIMEOUT_EN adds an input-idle timeout that forces FAIL.
module tile_sequence_checker
  import tile_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned SHOW_CYCLES    = 50_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  localparam int unsigned LenW = $clog2(MAX_LEN + 1)
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            start_i,
  input  tile_t           random_num_i,
  input  logic            btn_valid_i,
  input  tile_t           btn_tile_i,
  output logic            show_valid_o,
  output tile_t           show_tile_o,
  output logic            busy_o,
  output logic [LenW-1:0] round_len_o,
  output logic [LenW-1:0] score_o,
  output logic            win_o,
  output logic            fail_o
);

  localparam int unsigned AddrW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned MaxCyc = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0]  ShowLast = CntW'(SHOW_CYCLES - 1);
  localparam logic [CntW-1:0]  GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [LenW-1:0]  LenOne   = LenW'(1);
  localparam logic [LenW-1:0]  MaxLenL  = LenW'(MAX_LEN);
  localparam logic [AddrW-1:0] AddrOne  = AddrW'(1);

`ifdef TILE_TIMEOUT_EN
  localparam int unsigned IdleW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdleW-1:0] IdleOne  = IdleW'(1);
  logic [IdleW-1:0] idle_q;
`endif

  tile_state_t     state_q;
  logic [CntW-1:0] dwell_q;
  logic [LenW-1:0] idx_q, len_q, score_q;
  logic            show_valid_q, busy_q, win_q, fail_q;
  tile_t           show_tile_q;

  logic [LenW-1:0]  last_idx;
  logic [AddrW-1:0] rd_addr;
  tile_t            rd_tile;
  logic             buf_we;

  assign last_idx = len_q - LenOne;
  assign buf_we   = (state_q == StCapture);

  // Read address: first tile when starting playback, next tile when leaving GAP,
  // otherwise the current play/check index.
  always_comb begin
    rd_addr = idx_q[AddrW-1:0];
    if (state_q == StCapture) begin
      rd_addr = '0;
    end else if (state_q == StGap) begin
      rd_addr = idx_q[AddrW-1:0] + AddrOne;
    end
  end

  tile_seq_buffer #(
    .Depth (MAX_LEN)
  ) u_buffer (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (last_idx[AddrW-1:0]),
    .wdata_i (random_num_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_tile)
  );

  // Game FSM with registered outputs, counters and score.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= StIdle;
      dwell_q      <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      score_q      <= '0;
      show_valid_q <= 1'b0;
      show_tile_q  <= '0;
      busy_q       <= 1'b0;
      win_q        <= 1'b0;
      fail_q       <= 1'b0;
`ifdef TILE_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StWin, StFail: begin
          if (start_i) begin
            len_q   <= LenOne;
            score_q <= '0;
            win_q   <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StCapture;
          end
        end
        StCapture: begin
          idx_q        <= '0;
          dwell_q      <= '0;
          show_valid_q <= 1'b1;
          // On a one-tile round the first tile is being written this very edge.
          show_tile_q  <= (last_idx == '0) ? random_num_i : rd_tile;
          state_q      <= StShow;
        end
        StShow: begin
          if (dwell_q == ShowLast) begin
            dwell_q      <= '0;
            show_valid_q <= 1'b0;
            show_tile_q  <= '0;
            state_q      <= StGap;
          end else begin
            dwell_q <= dwell_q + CntOne;
          end
        end
        StGap: begin
          if (dwell_q == GapLast) begin
            dwell_q <= '0;
            if (idx_q == last_idx) begin
              idx_q   <= '0;
              state_q <= StInput;
`ifdef TILE_TIMEOUT_EN
              idle_q  <= '0;
`endif
            end else begin
              idx_q        <= idx_q + LenOne;
              show_valid_q <= 1'b1;
              show_tile_q  <= rd_tile;
              state_q      <= StShow;
            end
          end else begin
            dwell_q <= dwell_q + CntOne;
          end
        end
        StInput: begin
          if (btn_valid_i) begin
`ifdef TILE_TIMEOUT_EN
            idle_q <= '0;
`endif
            if (btn_tile_i != rd_tile) begin
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StFail;
            end else if (idx_q == last_idx) begin
              state_q <= StCheckEnd;
            end else begin
              idx_q <= idx_q + LenOne;
            end
          end
`ifdef TILE_TIMEOUT_EN
          else if (idle_q == IdleLast) begin
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFail;
          end else begin
            idle_q <= idle_q + IdleOne;
          end
`endif
        end
        StCheckEnd: begin
          score_q <= score_q + LenOne;
          if (len_q == MaxLenL) begin
            win_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StWin;
          end else begin
            len_q   <= len_q + LenOne;
            state_q <= StCapture;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign show_valid_o = show_valid_q;
  assign show_tile_o  = show_tile_q;
  assign busy_o       = busy_q;
  assign round_len_o  = len_q;
  assign score_o      = score_q;
  assign win_o        = win_q;
  assign fail_o       = fail_q;

endmodule

// File: tb/tb_tile_sequence_checker.sv
// Bench for tile_sequence_checker: schedule-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_tile_sequence_checker;
  import tile_pkg::*;

  localparam int unsigned MaxLen = 4;
  localparam int unsigned Show   = 4;
  localparam int unsigned Gap    = 2;
  localparam int unsigned Tmo    = 20;
  localparam int unsigned P      = Show + Gap;
  localparam int unsigned LW     = $clog2(MaxLen + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          btn_valid = 1'b0;
  logic [2:0]    random_num = 3'd0;
  logic [2:0]    btn_tile = 3'd0;
  logic          show_valid, busy, win, fail;
  logic [2:0]    show_tile;
  logic [LW-1:0] round_len, score;

  int n_cmp = 0;
  int n_bad = 0;

  tile_sequence_checker #(
    .MAX_LEN        (MaxLen),
    .SHOW_CYCLES    (Show),
    .GAP_CYCLES     (Gap),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .start_i      (start),
    .random_num_i (random_num),
    .btn_valid_i  (btn_valid),
    .btn_tile_i   (btn_tile),
    .show_valid_o (show_valid),
    .show_tile_o  (show_tile),
    .busy_o       (busy),
    .round_len_o  (round_len),
    .score_o      (score),
    .win_o        (win),
    .fail_o       (fail)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (timeline based) ----------------
  int unsigned n_edge = 0;     // posedges seen
  int unsigned cap_edge = 0;   // edge after which the round's capture cycle runs
  int unsigned last_act = 0;   // edge of INPUT entry or latest press
  int unsigned m_len = 0, m_score = 0, m_pressed = 0;
  bit          m_active = 0, m_pend = 0, m_win = 0, m_fail = 0;
  logic [2:0]  m_seq [MaxLen];

  // Player is being asked for input in the cycle following edge e.
  function automatic bit in_input_at(int unsigned e);
    return m_active && !m_pend && ((e - cap_edge) >= m_len * P + 1);
  endfunction

  task automatic model_reset();
    m_active = 0; m_pend = 0; m_win = 0; m_fail = 0;
    m_len = 0; m_score = 0; m_pressed = 0;
  endtask

  task automatic model_step();
    bit was_input;
    was_input = in_input_at(n_edge);
    n_edge++;
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_win = 0; m_fail = 0; m_len = 1; m_score = 0;
        m_pressed = 0; cap_edge = n_edge;
      end
    end else if (m_pend) begin
      m_pend = 0;
      m_score++;
      if (m_len == MaxLen) begin
        m_win = 1; m_active = 0;
      end else begin
        m_len++; m_pressed = 0; cap_edge = n_edge;
      end
    end else begin
      if (n_edge == cap_edge + 1) m_seq[m_len-1] = random_num;
      if (was_input) begin
        if (btn_valid) begin
          last_act = n_edge;
          if (btn_tile == m_seq[m_pressed]) begin
            m_pressed++;
            if (m_pressed == m_len) m_pend = 1;
          end else begin
            m_fail = 1; m_active = 0;
          end
        end
`ifdef TILE_TIMEOUT_EN
        else if (n_edge - last_act == Tmo) begin
          m_fail = 1; m_active = 0;
        end
`endif
      end
    end
    if (!was_input && in_input_at(n_edge)) last_act = n_edge;
  endtask

  function automatic logic [12:0] model_out();
    logic        sv;
    logic [2:0]  tl;
    int unsigned t, k;
    sv = 1'b0;
    tl = 3'd0;
    if (m_active && !m_pend) begin
      t = n_edge - cap_edge;
      if (t >= 1 && t <= m_len * P) begin
        k = t - 1;
        if ((k % P) < Show) begin
          sv = 1'b1;
          tl = m_seq[k / P];
        end
      end
    end
    return {sv, tl, m_active, LW'(m_len), LW'(m_score), m_win, m_fail};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    logic [12:0] exp_v, act_v;
    @(negedge clk);
    if (rst_n) begin
      exp_v = model_out();
      act_v = {show_valid, show_tile, busy, round_len, score, win, fail};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_outputs edge %0d: got sv=%0d tile=%0d busy=%0d len=%0d score=%0d win=%0d fail=%0d, expected sv=%0d tile=%0d busy=%0d len=%0d score=%0d win=%0d fail=%0d",
                 n_edge, act_v[12], act_v[11:9], act_v[8], act_v[7:5], act_v[4:2], act_v[1],
                 act_v[0], exp_v[12], exp_v[11:9], exp_v[8], exp_v[7:5], exp_v[4:2], exp_v[1],
                 exp_v[0]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [2:0] t);
    btn_valid = 1'b1;
    btn_tile  = t;
    @(negedge clk);
    btn_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_input();
    int i;
    i = 0;
    while (!in_input_at(n_edge) && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (!in_input_at(n_edge)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_input: INPUT not reached within 300 cycles, got busy=%0d, expected INPUT",
               busy);
    end
  endtask

  task automatic wait_show();
    int i;
    i = 0;
    while (!show_valid && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("wait_show_valid", show_valid, 1);
  endtask

  initial begin
    logic [2:0] seq [4];
    int hi;
    seq[0] = 3'd1; seq[1] = 3'd2; seq[2] = 3'd7; seq[3] = 3'd0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({show_valid, show_tile, busy, round_len, score, win, fail}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Round 1: tile 5.
    random_num = 3'd5;
    pulse_start();
    chk("capture_busy", busy, 1);
    chk("capture_show_valid", show_valid, 0);
    @(negedge clk);
    chk("r1_show_valid", show_valid, 1);
    chk("r1_show_tile", show_tile, 5);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (!show_valid) break;
      hi++;
      @(negedge clk);
    end
    chk("r1_show_cycles", hi, 4);
    random_num = 3'd3;
    wait_input();
    press(3'd5);
    chk("r1_score", score, 1);
    chk("r1_round_len", round_len, 2);

    // Round 2 (5,3): wrong second press.
    wait_input();
    press(3'd5);
    press(3'd6);
    chk("wrong_fail", fail, 1);
    chk("wrong_score", score, 1);
    chk("wrong_busy", busy, 0);
    chk("wrong_round_len", round_len, 2);

    // Full game 1,2,7,0 with ignored inputs sprinkled in.
    random_num = seq[0];
    pulse_start();
    chk("restart_round_len", round_len, 1);
    chk("restart_fail", fail, 0);
    for (int r = 0; r < 4; r++) begin
      if (r == 1) begin
        wait_show();
        btn_valid = 1'b1;
        btn_tile  = 3'd4;
        @(negedge clk);
        btn_valid = 1'b0;
        chk("btn_in_show_len", round_len, 2);
        chk("btn_in_show_score", score, 1);
      end
      wait_input();
      random_num = 3'd6;
      if (r == 2) begin
        pulse_start();
        chk("start_in_input_busy", busy, 1);
        chk("start_in_input_len", round_len, 3);
      end
      for (int j = 0; j <= r; j++) begin
        if (j == r && r < 3) random_num = seq[r+1];
        if (r == 3 && j == 0) start = 1'b1;
        press(seq[j]);
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("win_flag", win, 1);
    chk("win_score", score, 4);
    chk("win_round_len", round_len, 4);
    chk("win_busy", busy, 0);
    press(3'd3);
    chk("win_hold_flag", win, 1);
    chk("win_hold_score", score, 4);

    // Input timeout.
    random_num = 3'd4;
    pulse_start();
    wait_input();
`ifdef TILE_TIMEOUT_EN
    repeat (Tmo - 1) @(negedge clk);
    chk("timeout_not_yet", fail, 0);
    @(negedge clk);
    chk("timeout_fail", fail, 1);
    chk("timeout_score", score, 0);
    chk("timeout_busy", busy, 0);
`else
    repeat (100) @(negedge clk);
    chk("no_timeout_busy", busy, 1);
    chk("no_timeout_fail", fail, 0);
`endif

    // Reset mid-SHOW.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    random_num = 3'd2;
    pulse_start();
    wait_show();
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midshow_reset_sv", show_valid, 0);
    chk("midshow_reset_outputs",
        int'({show_valid, show_tile, busy, round_len, score, win, fail}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_reset_busy", busy, 0);
    chk("after_reset_len", round_len, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
